ahb_lite_sram_slave: RTL and testbench
======================================

# ahb_lite_sram_slave

Parametrised AHB-Lite slave memory that answers the bus signals carried by the verification interface (HSEL/HADDR/HTRANS/HSIZE/HWRITE/HWDATA/HREADY in; HRDATA/HREADYOUT/HRESP out). It is the bus-facing DUT target for the driver and monitor. It generalises a fixed 32-bit slave with:
- configurable data width, depth and wait states;
- byte/halfword/word (and dword) lanes;
- the two-cycle ERROR response for illegal transfers.

## Interface
Parameters:
- DATA_WIDTH, 32: bus data width; legal values are 32 or 64.
- ADDR_WIDTH, 32: HADDR width.
- MEM_DEPTH, 1024: number of DATA_WIDTH-bit words; byte capacity is MEM_DEPTH*DATA_WIDTH/8.
- WAIT_STATES, 0: wait cycles inserted per OKAY data phase, 0..15.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETn  in  1  reset; synchronous and active-low.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_WIDTH  byte address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, 2^HSIZE bytes.
- HBURST  in  3  accepted, not interpreted.
- HPROT  in  4  accepted, not interpreted.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADY  in  1  bus ready; the address phase is sampled only when this is 1.
- HRDATA  out  DATA_WIDTH  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Transfer accepted at a rising edge when HSEL=1, HREADY=1 and HTRANS[1]=1. The slave then registers HADDR, HSIZE and HWRITE.
- IDLE, BUSY, or HSEL=0 with HREADY=1: no transfer; the following cycle is an OKAY zero-wait response.
- Error check at acceptance. A transfer is illegal if any of these holds:
  - HADDR >= byte capacity;
  - HSIZE > log2(DATA_WIDTH/8);
  - HADDR is not aligned to 2^HSIZE.
- An illegal transfer causes no memory access.
- State machine:
  - IDLE (HREADYOUT=1, HRESP=0).
  - WAIT (HREADYOUT=0, HRESP=0; down-counter loaded with WAIT_STATES).
  - ACCESS (HREADYOUT=1, HRESP=0).
  - ERR1 (HREADYOUT=0, HRESP=1).
  - ERR2 (HREADYOUT=1, HRESP=1).
- Transitions out of IDLE, ACCESS and ERR2, evaluated on the sampled address phase:
  - illegal transfer -> ERR1;
  - legal transfer with WAIT_STATES>0 -> WAIT;
  - legal transfer with WAIT_STATES=0 -> ACCESS;
  - no transfer -> IDLE.
- WAIT stays in WAIT until the counter reaches 1, then goes to ACCESS.
- ERR1 always goes to ERR2.
- Address-phase sampling is suppressed in WAIT and ERR1, because HREADY is low in those states.
- Byte lanes are little-endian. The lane offset is HADDR[log2(DATA_WIDTH/8)-1:0].
- Write: on the rising edge that ends ACCESS, only the addressed lanes of HWDATA are written to word HADDR/(DATA_WIDTH/8). Other lanes are untouched.
- Read: in ACCESS, HRDATA carries the full addressed word on all lanes. The master selects lanes. In every other state HRDATA=0.
- The memory array is not reset and is undefined until written.

## Timing
- Reset values (HRESETn=0 at an edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0.
- Latency: the data phase lasts WAIT_STATES+1 cycles after acceptance. Read data is valid in the cycle in which HREADYOUT=1.
- Error response: exactly 2 cycles, with HRESP=1 in both and HREADYOUT 0 then 1.
- Back-to-back transfers: a new address phase may be accepted in the ACCESS or ERR2 cycle, giving pipelined operation with no bubble.
- Read-after-write to the same address, back-to-back: the read returns the newly written data with no extra stall.
- Master drives IDLE during ERR2: the slave returns to IDLE next cycle.
- Reset asserted mid-transfer (in WAIT or ACCESS): the pending write is discarded and outputs take their reset values at that edge.
- WAIT_STATES=0: the WAIT state is never entered.

## Test plan
- Reset: hold HRESETn=0 for 3 cycles with HTRANS=NONSEQ -> HREADYOUT=1, HRESP=0, HRDATA=0 throughout, and no write occurs.
- Word write then read, DATA_WIDTH=32, WAIT_STATES=0: write 0xDEADBEEF to 0x10, then immediately read 0x10 -> HRDATA=0xDEADBEEF in the cycle after the read address phase, with no stall.
- Byte and halfword lanes: write word 0x11223344 to 0x20, then byte 0xAA to 0x21, then halfword 0x5566 to 0x22 -> reading 0x20 returns 0x5566AA44.
- Wait states, WAIT_STATES=3: read -> HREADYOUT is 0,0,0,1 across the data phase, and data is valid in the 4th cycle only.
- Errors, MEM_DEPTH=1024: each of the following -> HRESP=1 for 2 cycles with HREADYOUT 0 then 1, memory unchanged:
  - word write to 0x1000 (out of range);
  - halfword read at 0x3 (misaligned);
  - HSIZE=3 on a 32-bit bus (size too large).
- IDLE/BUSY and deselect: HTRANS=BUSY, or HSEL=0 with NONSEQ -> OKAY zero-wait response, and a following read shows memory unchanged.

Source files
------------

// File: rtl/ahb_lite_sram_slave_if.sv
// ahb_lite_sram_slave_if: AHB-Lite bus signals between a master and the SRAM slave
interface ahb_lite_sram_slave_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  HSEL;
   logic [ADDR_WIDTH-1:0] HADDR;
   logic [1:0]            HTRANS;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [2:0]            HBURST;
   logic [3:0]            HPROT;
   logic [DATA_WIDTH-1:0] HWDATA;
   logic                  HREADY;
   logic [DATA_WIDTH-1:0] HRDATA;
   logic                  HREADYOUT;
   logic                  HRESP;
   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );
   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite SRAM slave with byte lanes, wait states and two-cycle ERROR
module ahb_lite_sram_slave #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0
) (
   input logic                    i_hclk,
   input logic                    i_hresetn,
   ahb_lite_sram_slave_if.slave   s_ahb
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int OW = $clog2(NB);
   localparam int WW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int RW = OW + WW;
   localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH + 1)'(MEM_DEPTH * NB);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_ERR1, S_ERR2} state_t;

   state_t                r_state, w_next;
   logic [3:0]            r_cnt;
   logic [RW-1:0]         r_addr;
   logic [2:0]            r_size;
   logic                  r_write;
   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
   logic                  w_phase, w_accept, w_illegal, w_unused;
   logic [OW-1:0]         w_amask;
   logic [NB-1:0]         w_be;
   logic [WW-1:0]         w_widx;
   logic [DATA_WIDTH-1:0] w_word;

   assign w_phase   = r_state inside {S_IDLE, S_ACCESS, S_ERR2};
   assign w_accept  = w_phase & s_ahb.HSEL & s_ahb.HREADY & s_ahb.HTRANS[1];
   assign w_amask   = OW'((8'd1 << s_ahb.HSIZE) - 8'd1);
   assign w_illegal = ({1'b0, s_ahb.HADDR} >= CAP) | (s_ahb.HSIZE > 3'(OW))
                    | (|(s_ahb.HADDR[OW-1:0] & w_amask));
   assign w_widx    = r_addr[RW-1:OW];
   assign w_word    = r_mem[w_widx];
   assign w_unused  = ^{s_ahb.HTRANS[0], s_ahb.HBURST, s_ahb.HPROT};

   assign s_ahb.HREADYOUT = !(r_state inside {S_WAIT, S_ERR1});
   assign s_ahb.HRESP     = r_state inside {S_ERR1, S_ERR2};
   assign s_ahb.HRDATA    = (r_state == S_ACCESS) ? w_word : '0;

   // next state: sampling states branch on the address phase, WAIT counts down, ERR1 always to ERR2
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_WAIT:  w_next = (r_cnt == 4'd1) ? S_ACCESS : S_WAIT;
         S_ERR1:  w_next = S_ERR2;
         default: w_next = !w_accept ? S_IDLE : w_illegal ? S_ERR1 :
                           (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      endcase
   end

   // lanes covered by the registered transfer: 2^size bytes starting at the lane offset
   always_comb begin
      w_be = '0;
      for (int b = 0; b < NB; b++)
         w_be[b] = (b >= int'(r_addr[OW-1:0])) && (b < int'(r_addr[OW-1:0]) + (1 << r_size));
   end

   // state, wait counter and captured address phase
   always_ff @(posedge i_hclk) begin
      if (!i_hresetn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_size  <= '0;
         r_write <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state == S_WAIT) ? r_cnt - 4'd1 : (w_next == S_WAIT) ? 4'(WAIT_STATES) : '0;
         if (w_accept) begin
            r_addr  <= s_ahb.HADDR[RW-1:0];
            r_size  <= s_ahb.HSIZE;
            r_write <= s_ahb.HWRITE;
         end
      end
   end

   // byte-lane write at the edge that ends ACCESS; a reset on that edge drops it
   always_ff @(posedge i_hclk) begin
      if (i_hresetn && r_state == S_ACCESS && r_write)
         for (int b = 0; b < NB; b++)
            if (w_be[b]) r_mem[w_widx][8*b +: 8] <= s_ahb.HWDATA[8*b +: 8];
   end
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: directed checks of the AHB-Lite SRAM slave, zero and three wait states
module tb_ahb_lite_sram_slave;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   n_tot = 0;
   int   n_bad = 0;

   ahb_lite_sram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b0 ();
   ahb_lite_sram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b1 ();
   assign b0.HREADY = b0.HREADYOUT;
   assign b1.HREADY = b1.HREADYOUT;

   ahb_lite_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0))
      dut0 (.i_hclk(clk), .i_hresetn(rstn), .s_ahb(b0));
   ahb_lite_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(3))
      dut1 (.i_hclk(clk), .i_hresetn(rstn), .s_ahb(b1));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic ap0(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] a);
      b0.HSEL = sel; b0.HTRANS = trans; b0.HWRITE = wr; b0.HSIZE = size; b0.HADDR = a;
   endtask

   task automatic ap1(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] a);
      b1.HSEL = sel; b1.HTRANS = trans; b1.HWRITE = wr; b1.HSIZE = size; b1.HADDR = a;
   endtask

   task automatic wr0(input logic [31:0] a, input logic [2:0] size, input logic [31:0] d);
      ap0(1, 2, 1, size, a);
      step;
      chk("wr_rdy", b0.HREADYOUT, 1);
      b0.HWDATA = d;
      ap0(0, 0, 0, 0, 0);
      step;
   endtask

   task automatic rd0(input string tag, input logic [31:0] a, input logic [31:0] exp);
      ap0(1, 2, 0, 2, a);
      step;
      chk(tag, b0.HRDATA, exp);
      chk({tag, "_rdy"}, b0.HREADYOUT, 1);
      ap0(0, 0, 0, 0, 0);
   endtask

   task automatic err0(input string tag, input logic [31:0] a, input logic [2:0] size,
                       input logic wr, input logic [31:0] d);
      ap0(1, 2, wr, size, a);
      step;
      chk({tag, "_e1_resp"}, b0.HRESP, 1);
      chk({tag, "_e1_rdy"}, b0.HREADYOUT, 0);
      chk({tag, "_e1_data"}, b0.HRDATA, 0);
      b0.HWDATA = d;
      ap0(0, 0, 0, 0, 0);
      step;
      chk({tag, "_e2_resp"}, b0.HRESP, 1);
      chk({tag, "_e2_rdy"}, b0.HREADYOUT, 1);
      step;
      chk({tag, "_idle_resp"}, b0.HRESP, 0);
      chk({tag, "_idle_rdy"}, b0.HREADYOUT, 1);
   endtask

   task automatic rd1(input string tag, input logic [31:0] a, input logic [31:0] exp);
      ap1(1, 2, 0, 2, a);
      step;
      ap1(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_rdy"}, b1.HREADYOUT, (i == 3) ? 1'b1 : 1'b0);
         chk({tag, "_data"}, b1.HRDATA, (i == 3) ? exp : 32'h0);
         step;
      end
   endtask

   initial begin
      b0.HBURST = 0; b0.HPROT = 0; b0.HWDATA = 0;
      b1.HBURST = 0; b1.HPROT = 0; b1.HWDATA = 0;
      ap1(0, 0, 0, 0, 0);
      ap0(1, 2, 1, 2, 32'h10);
      b0.HWDATA = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         step;
         chk("rst_rdy", b0.HREADYOUT, 1);
         chk("rst_resp", b0.HRESP, 0);
         chk("rst_data", b0.HRDATA, 0);
      end
      rstn = 1'b1;
      ap0(0, 0, 0, 0, 0);
      step;

      ap0(1, 2, 1, 2, 32'h10);
      step;
      chk("raw_wr_rdy", b0.HREADYOUT, 1);
      b0.HWDATA = 32'hDEAD_BEEF;
      ap0(1, 2, 0, 2, 32'h10);
      step;
      chk("raw_data", b0.HRDATA, 32'hDEAD_BEEF);
      chk("raw_rdy", b0.HREADYOUT, 1);
      ap0(0, 0, 0, 0, 0);
      step;
      chk("idle_data", b0.HRDATA, 0);

      wr0(32'h20, 2, 32'h1122_3344);
      wr0(32'h21, 0, 32'hFFFF_AAFF);
      wr0(32'h22, 1, 32'h5566_EEEE);
      rd0("lanes", 32'h20, 32'h5566_AA44);

      wr0(32'h0, 2, 32'h0102_0304);
      err0("oor", 32'h1000, 2, 1, 32'hFFFF_FFFF);
      rd0("oor_mem", 32'h0, 32'h0102_0304);
      err0("mis", 32'h3, 1, 0, 32'h0);
      err0("big", 32'h10, 3, 1, 32'hFFFF_FFFF);
      rd0("big_mem", 32'h10, 32'hDEAD_BEEF);

      ap0(1, 1, 1, 2, 32'h20);
      step;
      chk("busy_rdy", b0.HREADYOUT, 1);
      chk("busy_resp", b0.HRESP, 0);
      b0.HWDATA = 32'h0;
      ap0(0, 2, 1, 2, 32'h20);
      step;
      chk("desel_rdy", b0.HREADYOUT, 1);
      chk("desel_resp", b0.HRESP, 0);
      b0.HWDATA = 32'h0;
      ap0(0, 0, 0, 0, 0);
      step;
      rd0("desel_mem", 32'h20, 32'h5566_AA44);

      ap1(1, 2, 1, 2, 32'h40);
      step;
      b1.HWDATA = 32'hCAFE_F00D;
      ap1(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         chk("ws_wr_rdy", b1.HREADYOUT, (i == 3) ? 1'b1 : 1'b0);
         step;
      end
      rd1("ws_rd", 32'h40, 32'hCAFE_F00D);

      ap1(1, 2, 1, 2, 32'h40);
      step;
      b1.HWDATA = 32'h1234_5678;
      ap1(0, 0, 0, 0, 0);
      step;
      rstn = 1'b0;
      step;
      chk("mid_rst_rdy", b1.HREADYOUT, 1);
      chk("mid_rst_resp", b1.HRESP, 0);
      chk("mid_rst_data", b1.HRDATA, 0);
      rstn = 1'b1;
      step;
      rd1("mid_rst_mem", 32'h40, 32'hCAFE_F00D);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
